inst_cache: RTL and testbench
=============================

INST_CACHE -- requirements
Module: inst_cache

Interface
REQ-001 Parameter WORD_SIZE, 32, instruction width in bits.
REQ-002 Parameter ADDR_W, 32, word-address width of ptr.
REQ-003 Parameter BLOCK_SIZE, 4, words per line; power of 2, >=2.
REQ-004 Parameter LINES, 8, number of direct-mapped lines; power of 2, >=2.
REQ-005 clk  in  1  clock, all state on rising edge.
REQ-006 rst_n  in  1  reset, asynchronous, active-low.
REQ-007 req  in  1  fetch request, sampled when busy=0.
REQ-008 ptr  in  ADDR_W  word address of the requested instruction.
REQ-009 flush  in  1  invalidate all lines.
REQ-010 inst  out  WORD_SIZE  fetched instruction, registered.
REQ-011 inst_valid  out  1  inst valid this cycle; single-cycle pulse per request.
REQ-012 busy  out  1  refill in progress; req ignored.
REQ-013 mem_req  out  1  block read request to instruction memory.
REQ-014 mem_addr  out  ADDR_W  block-aligned word address (offset bits zero).
REQ-015 mem_ready  in  1  mem_block valid this cycle; completes mem_req.
REQ-016 mem_block  in  WORD_SIZE*BLOCK_SIZE  word i at bits [WORD_SIZE*(i+1)-1 : WORD_SIZE*i].

Function
REQ-017 Address split: offset = ptr[OFFSET_W-1:0], index = next INDEX_W bits, tag = remaining high bits; OFFSET_W=clog2(BLOCK_SIZE), INDEX_W=clog2(LINES).
REQ-018 States: IDLE, MISS; busy=1 exactly in MISS.
REQ-019 IDLE, req=1, line valid and tag match (hit): inst=word[offset] and inst_valid=1 on next cycle; remain IDLE; back-to-back hits sustain one per cycle.
REQ-020 IDLE, req=1, miss: latch ptr, enter MISS; mem_req=1 and mem_addr=ptr with offset cleared from the following cycle.
REQ-021 MISS: hold mem_req and mem_addr stable until mem_ready=1; on that edge write block, tag, valid into line; next cycle inst=mem_block word[latched offset], inst_valid=1, mem_req=0, state IDLE.
REQ-022 mem_ready ignored in IDLE.
REQ-023 Miss latency: inst_valid exactly one cycle after the mem_ready cycle.
REQ-024 flush in IDLE: all valid bits cleared on that edge; a coincident req is looked up against the pre-flush array and completes normally, but its line is invalid afterwards.
REQ-025 flush in MISS: valid bits cleared; the in-flight refill still completes and its line is valid afterwards.
REQ-026 Conflict: refill overwrites any existing line at that index without write-back.
REQ-027 inst holds its last value while inst_valid=0.

Reset
REQ-028 rst_n low: state IDLE, all valid bits 0, inst=0, inst_valid=0, busy=0, mem_req=0, mem_addr=0, immediately and independent of clk.
REQ-029 Reset during MISS abandons the refill; a mem_ready after release is ignored; data arrays need no reset.

Configuration
REQ-030 Macro INST_CACHE_STATS_EN defined: outputs hit_count and miss_count (32 bits each) exist; each increments by 1 per hit/miss decision in IDLE, wraps 0xFFFFFFFF->0, reset to 0 by rst_n, unaffected by flush.
REQ-031 Macro undefined: those ports and counters are absent; all other behaviour identical.

Verification (WORD_SIZE 32, BLOCK_SIZE 4, LINES 8)
REQ-032 After reset, req ptr=1 -> miss; mem_req=1, mem_addr=0; mem_ready after 3 cycles with words {A0,A1,A2,A3} -> next cycle inst=A1, inst_valid=1.
REQ-033 Then req ptr=2, ptr=3 on consecutive cycles -> inst=A2 then A3, one cycle each, mem_req stays 0.
REQ-034 req ptr=35 (index 0, tag 1) -> miss, mem_addr=32, inst=word 3 of returned block; then req ptr=1 -> miss again, mem_addr=0.
REQ-035 flush pulse in IDLE, then req ptr=2 -> miss, mem_req=1, mem_addr=0.
REQ-036 rst_n low while in MISS -> mem_req=0 and busy=0 without clock edge; after release, mem_ready pulse -> no inst_valid; req ptr=2 -> miss.
REQ-037 With INST_CACHE_STATS_EN, sequence of REQ-032..034 -> hit_count=2, miss_count=3.

Source files
------------

// File: rtl/inst_cache.sv
// Direct-mapped instruction cache with single-outstanding block refill.
// Optional hit/miss counters are enabled by defining INST_CACHE_STATS_EN.
module inst_cache #(
    parameter int WORD_SIZE  = 32,
    parameter int ADDR_W     = 32,
    parameter int BLOCK_SIZE = 4,
    parameter int LINES      = 8
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           req,
    input  logic [ADDR_W-1:0]              ptr,
    input  logic                           flush,
    output logic [WORD_SIZE-1:0]           inst,
    output logic                           inst_valid,
    output logic                           busy,
    output logic                           mem_req,
    output logic [ADDR_W-1:0]              mem_addr,
    input  logic                           mem_ready,
    input  logic [WORD_SIZE*BLOCK_SIZE-1:0] mem_block
`ifdef INST_CACHE_STATS_EN
    ,
    output logic [31:0]                    hit_count,
    output logic [31:0]                    miss_count
`endif
);

    localparam int OFFSET_W = $clog2(BLOCK_SIZE);
    localparam int INDEX_W  = $clog2(LINES);
    localparam int TAG_W    = ADDR_W - OFFSET_W - INDEX_W;

    typedef enum logic {
        IDLE,
        MISS
    } state_e;

    state_e state, state_d;

    logic [WORD_SIZE-1:0] data_mem [LINES][BLOCK_SIZE];
    logic [TAG_W-1:0]     tag_mem  [LINES];
    logic [LINES-1:0]     valid, valid_d;

    logic [OFFSET_W-1:0]  miss_off;
    logic [WORD_SIZE-1:0] fill_words [BLOCK_SIZE];

    logic [OFFSET_W-1:0]  req_offset;
    logic [INDEX_W-1:0]   req_index;
    logic [TAG_W-1:0]     req_tag;
    logic [INDEX_W-1:0]   miss_index;
    logic [TAG_W-1:0]     miss_tag;

    logic                 lookup_hit;
    logic                 start_miss;
    logic                 refill;
    logic                 inst_valid_d;
    logic [WORD_SIZE-1:0] inst_d;

    assign req_offset = ptr[OFFSET_W-1:0];
    assign req_index  = ptr[OFFSET_W +: INDEX_W];
    assign req_tag    = ptr[ADDR_W-1 -: TAG_W];

    // The latched block address doubles as the refill target.
    assign miss_index = mem_addr[OFFSET_W +: INDEX_W];
    assign miss_tag   = mem_addr[ADDR_W-1 -: TAG_W];

    assign lookup_hit = valid[req_index] && (tag_mem[req_index] == req_tag);

    assign busy    = (state == MISS);
    assign mem_req = (state == MISS);

    always_comb begin
        for (int i = 0; i < BLOCK_SIZE; i++) begin
            fill_words[i] = mem_block[i*WORD_SIZE +: WORD_SIZE];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    // NOTE: every output of a combinational block gets a default first so
    // no path through the case leaves it unassigned, which would infer a latch.
    always_comb begin
        state_d      = state;
        start_miss   = 1'b0;
        refill       = 1'b0;
        inst_valid_d = 1'b0;
        inst_d       = '0;
        case (state)
            IDLE: begin
                if (req) begin
                    if (lookup_hit) begin
                        inst_valid_d = 1'b1;
                        inst_d       = data_mem[req_index][req_offset];
                    end else begin
                        start_miss = 1'b1;
                        state_d    = MISS;
                    end
                end
            end
            MISS: begin
                if (mem_ready) begin
                    refill       = 1'b1;
                    inst_valid_d = 1'b1;
                    inst_d       = fill_words[miss_off];
                    state_d      = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Flush clears first; a refill landing on the same edge still marks its line.
    always_comb begin
        valid_d = valid;
        if (flush) begin
            valid_d = '0;
        end
        if (refill) begin
            valid_d[miss_index] = 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid      <= '0;
            inst       <= '0;
            inst_valid <= 1'b0;
            mem_addr   <= '0;
            miss_off   <= '0;
        end else begin
            valid      <= valid_d;
            inst_valid <= inst_valid_d;
            if (inst_valid_d) begin
                inst <= inst_d;
            end
            if (start_miss) begin
                mem_addr <= {ptr[ADDR_W-1:OFFSET_W], {OFFSET_W{1'b0}}};
                miss_off <= req_offset;
            end
        end
    end

    // NOTE: data and tag arrays carry no reset; the valid bits alone gate their use.
    always_ff @(posedge clk) begin
        if (refill) begin
            for (int i = 0; i < BLOCK_SIZE; i++) begin
                data_mem[miss_index][i] <= fill_words[i];
            end
            tag_mem[miss_index] <= miss_tag;
        end
    end

`ifdef INST_CACHE_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hit_count  <= '0;
            miss_count <= '0;
        end else begin
            if (state == IDLE && req && lookup_hit) begin
                hit_count <= hit_count + 32'd1;
            end
            if (start_miss) begin
                miss_count <= miss_count + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_inst_cache.sv
// Self-checking bench for inst_cache: directed table, corner sequences,
// and randomized fetches against a line-level reference model.
module tb_inst_cache;

    localparam int W = 32;
    localparam int A = 32;
    localparam int B = 4;
    localparam int L = 8;

    logic           clk;
    logic           rst_n;
    logic           req;
    logic [A-1:0]   ptr;
    logic           flush;
    logic [W-1:0]   inst;
    logic           inst_valid;
    logic           busy;
    logic           mem_req;
    logic [A-1:0]   mem_addr;
    logic           mem_ready;
    logic [W*B-1:0] mem_block;
`ifdef INST_CACHE_STATS_EN
    logic [31:0]    hit_count;
    logic [31:0]    miss_count;
`endif

    inst_cache #(
        .WORD_SIZE (W),
        .ADDR_W    (A),
        .BLOCK_SIZE(B),
        .LINES     (L)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .ptr       (ptr),
        .flush     (flush),
        .inst      (inst),
        .inst_valid(inst_valid),
        .busy      (busy),
        .mem_req   (mem_req),
        .mem_addr  (mem_addr),
        .mem_ready (mem_ready),
        .mem_block (mem_block)
`ifdef INST_CACHE_STATS_EN
        ,
        .hit_count (hit_count),
        .miss_count(miss_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model: which memory block each line holds, if any.
    bit          m_valid [L];
    int unsigned m_blk   [L];
    int unsigned m_hits  = 0;
    int unsigned m_miss  = 0;
    logic [W-1:0] last_inst = '0;

    typedef struct {
        logic [A-1:0] p;
        int           lat;
        bit           exp_hit;
        logic [A-1:0] exp_addr;
    } vec_t;

    vec_t tbl [8];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [W-1:0] mem_word(input logic [A-1:0] a);
        return a * 32'h9E37_79B1 + 32'h0123_4567;
    endfunction

    function automatic bit model_hit(input logic [A-1:0] p);
        int unsigned blk = p / B;
        return m_valid[blk % L] && (m_blk[blk % L] == blk);
    endfunction

    task automatic model_clear();
        for (int i = 0; i < L; i++) m_valid[i] = 1'b0;
    endtask

    task automatic model_reset();
        model_clear();
        m_hits = 0;
        m_miss = 0;
    endtask

    // One request; a miss is answered after lat wait cycles, optionally
    // with a flush pulse during the first wait cycle.
    task automatic fetch(input logic [A-1:0] p, input int lat, input bit exp_hit,
                         input logic [A-1:0] exp_addr, input bit mid_flush, input string nm);
        logic [W*B-1:0] blk;
        logic [W-1:0]   exp_w;
        int unsigned    b;
        exp_w = mem_word(p);
        b     = p / B;
        req = 1'b1;
        ptr = p;
        step();
        req = 1'b0;
        if (exp_hit) begin
            m_hits++;
            check({nm, " hit valid"}, 64'(inst_valid), 64'd1);
            check({nm, " hit inst"}, 64'(inst), 64'(exp_w));
            check({nm, " hit no mem_req"}, 64'(mem_req), 64'd0);
        end else begin
            m_miss++;
            check({nm, " miss busy"}, 64'(busy), 64'd1);
            check({nm, " miss mem_req"}, 64'(mem_req), 64'd1);
            check({nm, " miss mem_addr"}, 64'(mem_addr), 64'(exp_addr));
            check({nm, " miss no valid"}, 64'(inst_valid), 64'd0);
            for (int c = 0; c < lat; c++) begin
                flush = mid_flush && (c == 0);
                step();
                if (flush) model_clear();
                flush = 1'b0;
            end
            if (lat > 0) begin
                check({nm, " mem_req held"}, 64'(mem_req), 64'd1);
                check({nm, " mem_addr held"}, 64'(mem_addr), 64'(exp_addr));
            end
            for (int i = 0; i < B; i++) blk[i*W +: W] = mem_word(b * B + i);
            mem_ready = 1'b1;
            mem_block = blk;
            step();
            mem_ready = 1'b0;
            mem_block = '0;
            check({nm, " refill valid"}, 64'(inst_valid), 64'd1);
            check({nm, " refill inst"}, 64'(inst), 64'(exp_w));
            check({nm, " refill mem_req off"}, 64'(mem_req), 64'd0);
            check({nm, " refill idle"}, 64'(busy), 64'd0);
            m_valid[b % L] = 1'b1;
            m_blk[b % L]   = b;
        end
        last_inst = exp_w;
    endtask

    initial begin
        rst_n     = 1'b0;
        req       = 1'b0;
        ptr       = '0;
        flush     = 1'b0;
        mem_ready = 1'b0;
        mem_block = '0;
        model_reset();

        #2;
        check("reset inst", 64'(inst), 64'd0);
        check("reset inst_valid", 64'(inst_valid), 64'd0);
        check("reset busy", 64'(busy), 64'd0);
        check("reset mem_req", 64'(mem_req), 64'd0);
        check("reset mem_addr", 64'(mem_addr), 64'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        step();

        // Directed sequence: cold miss, sequential hits, conflict eviction.
        tbl[0] = '{p: 32'd1,  lat: 3, exp_hit: 1'b0, exp_addr: 32'd0};
        tbl[1] = '{p: 32'd2,  lat: 0, exp_hit: 1'b1, exp_addr: 32'd0};
        tbl[2] = '{p: 32'd3,  lat: 0, exp_hit: 1'b1, exp_addr: 32'd0};
        tbl[3] = '{p: 32'd35, lat: 2, exp_hit: 1'b0, exp_addr: 32'd32};
        tbl[4] = '{p: 32'd1,  lat: 1, exp_hit: 1'b0, exp_addr: 32'd0};
        tbl[5] = '{p: 32'd0,  lat: 0, exp_hit: 1'b1, exp_addr: 32'd0};
        tbl[6] = '{p: 32'd37, lat: 0, exp_hit: 1'b0, exp_addr: 32'd36};
        tbl[7] = '{p: 32'd38, lat: 0, exp_hit: 1'b1, exp_addr: 32'd36};
        for (int i = 0; i < 8; i++) begin
            fetch(tbl[i].p, tbl[i].lat, tbl[i].exp_hit, tbl[i].exp_addr, 1'b0,
                  $sformatf("vec%0d", i));
`ifdef INST_CACHE_STATS_EN
            if (i == 4) begin
                check("stats hits", 64'(hit_count), 64'd2);
                check("stats misses", 64'(miss_count), 64'd3);
            end
`endif
        end

        // Single-cycle pulse, inst holds while idle.
        step();
        check("pulse drops", 64'(inst_valid), 64'd0);
        check("inst holds", 64'(inst), 64'(last_inst));

        // Flush in IDLE, then re-fetch of a previously cached line misses.
        flush = 1'b1;
        step();
        flush = 1'b0;
        model_clear();
        fetch(32'd2, 1, 1'b0, 32'd0, 1'b0, "post-flush");

        // Flush coincident with a hit: hit served, line gone afterwards.
        req   = 1'b1;
        ptr   = 32'd3;
        flush = 1'b1;
        step();
        req   = 1'b0;
        flush = 1'b0;
        m_hits++;
        model_clear();
        check("flush+hit valid", 64'(inst_valid), 64'd1);
        check("flush+hit inst", 64'(inst), 64'(mem_word(32'd3)));
        fetch(32'd3, 0, 1'b0, 32'd0, 1'b0, "after flush+hit");

        // Flush during MISS: in-flight line survives, others are dropped.
        fetch(32'd70, 2, 1'b0, 32'd68, 1'b1, "flush-in-miss");
        fetch(32'd71, 0, 1'b1, 32'd68, 1'b0, "refilled line kept");
        fetch(32'd1, 0, 1'b0, 32'd0, 1'b0, "other line dropped");

        // mem_ready while idle is ignored.
        mem_ready = 1'b1;
        mem_block = '1;
        step();
        mem_ready = 1'b0;
        mem_block = '0;
        check("idle mem_ready ignored", 64'(inst_valid), 64'd0);

        // Reset during MISS: abandons refill immediately.
        req = 1'b1;
        ptr = 32'd130;
        step();
        req = 1'b0;
        check("pre-reset busy", 64'(busy), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async reset mem_req", 64'(mem_req), 64'd0);
        check("async reset busy", 64'(busy), 64'd0);
        check("async reset mem_addr", 64'(mem_addr), 64'd0);
        check("async reset inst", 64'(inst), 64'd0);
        model_reset();
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        step();
        mem_ready = 1'b1;
        mem_block = '1;
        step();
        mem_ready = 1'b0;
        mem_block = '0;
        check("stale mem_ready no valid", 64'(inst_valid), 64'd0);
        check("stale mem_ready idle", 64'(busy), 64'd0);
        fetch(32'd2, 1, 1'b0, 32'd0, 1'b0, "post-reset");

        // Randomized traffic over a small address window to force conflicts.
        for (int n = 0; n < 300; n++) begin
            logic [A-1:0] p;
            int           r;
            p = A'($urandom_range(0, 63));
            r = $urandom_range(0, 9);
            if (r == 0) begin
                flush = 1'b1;
                step();
                flush = 1'b0;
                model_clear();
            end else if (r == 1) begin
                mem_ready = 1'b1;
                mem_block = W*B'($urandom);
                step();
                mem_ready = 1'b0;
                mem_block = '0;
                check("rand idle mem_ready", 64'(inst_valid), 64'd0);
            end
            fetch(p, $urandom_range(0, 3), model_hit(p), {p[A-1:2], 2'b00},
                  ($urandom_range(0, 7) == 0), $sformatf("rand%0d", n));
        end

`ifdef INST_CACHE_STATS_EN
        check("final hits", 64'(hit_count), 64'(m_hits));
        check("final misses", 64'(miss_count), 64'(m_miss));
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
